// File: rtl/aes_key_expand_seq.sv
// ---------------------------------------------------------------------------
// aes_key_expand_seq
//   Sequential AES key-schedule generator for AES-128/192/256, mode chosen
//   per request. One 32-bit schedule word is produced per cycle through a
//   single 4-byte S-box lane. Every fourth word completes a 128-bit round
//   key, which is handed to the consumer over a valid/ready interface.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request an expansion (only looked at while idle)
//   key_len    : 00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   key_in     : cipher key, word w0 at [31:0], byte0 of a word at [31:24]
//   busy       : expansion in progress
//   cfg_err    : one-cycle pulse when a start carries an unusable key_len
//   rk_valid   : rk_data/rk_idx hold a round key
//   rk_ready   : consumer accepts the presented round key
//   rk_idx     : round number 0..Nr
//   rk_data    : round key, word 4r at [31:0] ... word 4r+3 at [127:96]
//   done       : one-cycle pulse after the last round key is accepted
// ---------------------------------------------------------------------------

// AES S-box for one byte: multiplicative inverse in GF(2^8) followed by the
// affine transform. The inverse is x^254, built from repeated squaring.
module sub_box (
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero as AES requires
  always_comb begin
    sq  = byte_val;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    sub_val = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_key_expand_seq #(
  parameter int MAX_KEY_W = 256,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           key_len,
  input  logic [MAX_KEY_W-1:0] key_in,
  output logic                 busy,
  output logic                 cfg_err,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [IDX_W-1:0]     rk_idx,
  output logic [127:0]         rk_data,
  output logic                 done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [9:0] MAX_W10 = 10'(MAX_KEY_W);

  logic [1:0]   state;
  logic [1:0]   len_reg;
  logic [255:0] key_full;
  logic [255:0] key_reg;
  logic [5:0]   word_i;
  logic [2:0]   word_mod;
  logic [7:0]   rcon;
  logic [31:0]  win [0:7];
  logic [31:0]  col [0:2];

  logic [3:0]   nk;
  logic [2:0]   nk_m1;
  logic [5:0]   last_word;
  logic [9:0]   req_bits;
  logic         len_ok;
  logic         accept;
  logic         reject;
  logic         is_key;
  logic         stall;
  logic         advance;
  logic         load;
  logic [31:0]  key_word;
  logic [31:0]  prev_word;
  logic [31:0]  rot_word;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp_word;
  logic [31:0]  new_word;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Widen the key port to 256 bits so word selection is uniform for any MAX_KEY_W
  always_comb begin
    key_full                  = '0;
    key_full[MAX_KEY_W-1:0]   = key_in;
  end

  // Mode-derived constants: Nk = 4/6/8, last word index = 4(Nr+1)-1 = 43/51/59
  always_comb begin
    nk        = 4'd4 + {1'b0, len_reg, 1'b0};
    nk_m1     = 3'd3 + {len_reg, 1'b0};
    last_word = 6'd43 + {1'b0, len_reg, 3'b000};
    req_bits  = 10'd128 + {2'b00, key_len, 6'b000000};
    len_ok    = (key_len != 2'b11) && (req_bits <= MAX_W10);
    // a start landing on the done cycle is deliberately dropped
    accept    = (state == IDLE) && start && !done && len_ok;
    reject    = (state == IDLE) && start && !done && !len_ok;
  end

  // Word generator: the window holds the last Nk words with win[0] = w[i-1],
  // so w[i-Nk] sits at win[Nk-1]. word_mod is i mod Nk without a divider.
  always_comb begin
    is_key    = ({2'b00, word_i} < {4'b0000, nk});
    key_word  = key_reg[{word_i[2:0], 5'b00000} +: 32];
    prev_word = win[0];
    rot_word  = {prev_word[23:0], prev_word[31:24]};
    sub_in    = (word_mod == 3'd0) ? rot_word : prev_word;
    if (word_mod == 3'd0) begin
      temp_word = sub_out ^ {rcon, 24'h000000};
    end else if ((len_reg == 2'b10) && (word_mod == 3'd4)) begin
      temp_word = sub_out;
    end else begin
      temp_word = prev_word;
    end
    new_word = is_key ? key_word : (win[nk_m1] ^ temp_word);
  end

  // Shared S-box lane, one instance per byte
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sub_box u_sub_box (
      .byte_val (sub_in[8*b +: 8]),
      .sub_val  (sub_out[8*b +: 8])
    );
  end

  // Hold off only when the word about to complete a round key would overwrite
  // an output register the consumer has not taken yet
  always_comb begin
    stall   = (word_i[1:0] == 2'b11) && rk_valid && !rk_ready;
    advance = (state == RUN) && !stall;
    load    = advance && (word_i[1:0] == 2'b11);
  end

  assign busy = (state != IDLE);

  // Control FSM: request acceptance, word counter, Rcon sequence and completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len_reg  <= 2'b00;
      key_reg  <= '0;
      word_i   <= '0;
      word_mod <= '0;
      rcon     <= 8'h00;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= reject;
      case (state)
        IDLE: begin
          if (accept) begin
            key_reg  <= key_full;
            len_reg  <= key_len;
            word_i   <= '0;
            word_mod <= '0;
            rcon     <= 8'h01;
            state    <= RUN;
          end
        end
        RUN: begin
          if (advance) begin
            word_i   <= word_i + 6'd1;
            word_mod <= (word_mod == nk_m1) ? 3'd0 : word_mod + 3'd1;
            if (!is_key && (word_mod == 3'd0)) rcon <= xtime(rcon);
            if (word_i == last_word) state <= FIN;
          end
        end
        FIN: begin
          if (rk_valid && rk_ready) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: word window, round-key collector and output register. A transfer
  // and a new load in the same cycle simply replace the register with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) win[k] <= '0;
      for (int k = 0; k < 3; k++) col[k] <= '0;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      rk_data  <= '0;
    end else begin
      if (advance) begin
        win[0] <= new_word;
        for (int k = 1; k < 8; k++) win[k] <= win[k-1];
        case (word_i[1:0])
          2'b00:   col[0] <= new_word;
          2'b01:   col[1] <= new_word;
          2'b10:   col[2] <= new_word;
          default: ;
        endcase
      end
      if (load) begin
        rk_data  <= {new_word, col[2], col[1], col[0]};
        rk_idx   <= IDX_W'(word_i[5:2]);
        rk_valid <= 1'b1;
      end else if (rk_valid && rk_ready) begin
        rk_valid <= 1'b0;
      end
    end
  end

endmodule
